de_mem_responder: RTL and testbench

//  Target end of the drawing-engine memory bus (de_req/de_ack/de_addr/de_nbyte/de_rnw/de_w_data/de_r_data).

---
 rtl/de_mem_responder.sv | 123 ++++++++++++
 tb/tb_de_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de_mem_responder.sv
// Drawing-engine memory bus target: one read or byte-masked write at a time against a fixed-latency SRAM.
// Optional address bounds check is enabled by defining DE_RESP_BOUNDS_EN.
module de_mem_responder #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MEM_WORDS   = 262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  output logic        resp_busy,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 4;

`ifdef DE_RESP_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            rnw_q;
  logic            drop_q;
  logic            addr_ok_d;
  logic            ack_q;
  logic            busy_q;
  logic            cs_q;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   addr_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;

  assign cnt_d     = cnt_q - CW'(1);
  assign addr_ok_d = !BOUNDS_EN || (32'(de_addr) < MEM_WORDS);

  // Transfer sequencer; out-of-range transfers walk the same states with the SRAM untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      drop_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      cs_q  <= 1'b0;
      we_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (de_req) begin
            addr_q  <= de_addr;
            be_q    <= de_rnw ? {BW{1'b1}} : ~de_nbyte;
            wdata_q <= de_w_data;
            cs_q    <= addr_ok_d;
            we_q    <= addr_ok_d && !de_rnw;
            rnw_q   <= de_rnw;
            drop_q  <= !addr_ok_d;
            if (!addr_ok_d) err_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= CW'(MEM_LATENCY);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            if (rnw_q) rdata_q <= drop_q ? '0 : mem_rdata;
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign de_ack    = ack_q;
  assign de_r_data = rdata_q;
  assign resp_busy = busy_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_de_mem_responder.sv
// Bench for de_mem_responder: two instances (latency 1 and 3) against bench SRAMs, a transaction-level
// timing/data model compared every cycle, plus directed literal expectations.
module tb_de_mem_responder;
  localparam int unsigned TB_WORDS = 1024;
`ifdef DE_RESP_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  logic        req   [2];
  logic        ack   [2];
  logic [17:0] addr  [2];
  logic [3:0]  nbyte [2];
  logic        rnw   [2];
  logic [31:0] wdata [2];
  logic [31:0] rdat  [2];
  logic        busy  [2];
  logic        cs    [2];
  logic        we    [2];
  logic [17:0] maddr [2];
  logic [3:0]  be    [2];
  logic [31:0] mwd   [2];
  logic [31:0] mrd   [2];
  logic        err   [2];

  logic [31:0] sram [2][64];
  logic [31:0] pipe [2][16];

  always #5 clk = ~clk;

  de_mem_responder #(.MEM_LATENCY(1), .MEM_WORDS(TB_WORDS)) u_l1 (
    .clk(clk), .rst(rst), .de_req(req[0]), .de_ack(ack[0]), .de_addr(addr[0]),
    .de_nbyte(nbyte[0]), .de_rnw(rnw[0]), .de_w_data(wdata[0]), .de_r_data(rdat[0]),
    .resp_busy(busy[0]), .mem_cs(cs[0]), .mem_we(we[0]), .mem_addr(maddr[0]),
    .mem_be(be[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]), .resp_err(err[0]));

  de_mem_responder #(.MEM_LATENCY(3), .MEM_WORDS(TB_WORDS)) u_l3 (
    .clk(clk), .rst(rst), .de_req(req[1]), .de_ack(ack[1]), .de_addr(addr[1]),
    .de_nbyte(nbyte[1]), .de_rnw(rnw[1]), .de_w_data(wdata[1]), .de_r_data(rdat[1]),
    .resp_busy(busy[1]), .mem_cs(cs[1]), .mem_we(we[1]), .mem_addr(maddr[1]),
    .mem_be(be[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]), .resp_err(err[1]));

  function automatic logic [31:0] init_word(input int k, input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hC0DE0000 + 32'(k * 256) + 32'(i);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Synchronous SRAMs; read data emerges latency cycles after the select cycle, junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 64; i++) sram[k][i] <= init_word(k, i);
      end else if (cs[k] && we[k]) begin
        for (int b = 0; b < 4; b++)
          if (be[k][b]) sram[k][maddr[k][5:0]][8*b +: 8] <= mwd[k][8*b +: 8];
      end
      if (cs[k] && !we[k]) pipe[k][0] <= sram[k][maddr[k][5:0]];
      else pipe[k][0] <= 32'hBAD00000 | 32'(k);
      for (int i = 1; i < 16; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end
  assign mrd[0] = pipe[0][0];
  assign mrd[1] = pipe[1][2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction model state
  int          acc     [2];
  int          next_ok [2];
  logic [17:0] e_addr  [2];
  logic [3:0]  e_be    [2];
  logic [31:0] e_wdata [2];
  logic        e_rnw   [2];
  logic        e_drop  [2];
  logic        e_err   [2];
  logic [31:0] e_pend  [2];
  logic [31:0] e_rd    [2];
  logic [31:0] mmem    [2][64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_model(input int k);
    acc[k] = -1; next_ok[k] = 0;
    e_addr[k] = '0; e_be[k] = '0; e_wdata[k] = '0; e_rnw[k] = 1'b0;
    e_drop[k] = 1'b0; e_err[k] = 1'b0; e_pend[k] = '0; e_rd[k] = '0;
  endtask

  task automatic model_step();
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) reset_model(k);
      else begin
        if (cyc >= next_ok[k] && req[k]) begin
          acc[k] = cyc;
          next_ok[k] = cyc + 3 + lat_of(k);
          e_addr[k] = addr[k];
          e_rnw[k] = rnw[k];
          e_be[k] = rnw[k] ? 4'hF : ~nbyte[k];
          e_wdata[k] = wdata[k];
          e_drop[k] = BOUNDS && (32'(addr[k]) >= TB_WORDS);
          if (e_drop[k]) begin
            e_err[k] = 1'b1;
            e_pend[k] = '0;
          end else if (rnw[k]) begin
            e_pend[k] = mmem[k][addr[k][5:0]];
          end else begin
            for (int b = 0; b < 4; b++)
              if (e_be[k][b]) mmem[k][addr[k][5:0]][8*b +: 8] = wdata[k][8*b +: 8];
          end
        end
        if (acc[k] >= 0 && cyc == acc[k] + 1 + lat_of(k) && e_rnw[k]) e_rd[k] = e_pend[k];
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      bit live;
      int l;
      if (rst) reset_model(k);
      live = acc[k] >= 0;
      l = lat_of(k);
      chk($sformatf("u%0d.de_ack", k), 32'(ack[k]), 32'(live && cyc == acc[k] + 1 + l));
      chk($sformatf("u%0d.mem_cs", k), 32'(cs[k]), 32'(live && cyc == acc[k] && !e_drop[k]));
      chk($sformatf("u%0d.mem_we", k), 32'(we[k]),
          32'(live && cyc == acc[k] && !e_drop[k] && !e_rnw[k]));
      chk($sformatf("u%0d.resp_busy", k), 32'(busy[k]),
          32'(live && cyc >= acc[k] && cyc <= acc[k] + 1 + l));
      chk($sformatf("u%0d.mem_addr", k), 32'(maddr[k]), 32'(e_addr[k]));
      chk($sformatf("u%0d.mem_be", k), 32'(be[k]), 32'(e_be[k]));
      chk($sformatf("u%0d.mem_wdata", k), mwd[k], e_wdata[k]);
      chk($sformatf("u%0d.de_r_data", k), rdat[k], e_rd[k]);
      chk($sformatf("u%0d.resp_err", k), 32'(err[k]), 32'(e_err[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_xfer(input int k, input bit rd_nwr, input logic [17:0] a, input logic [3:0] nb,
                          input logic [31:0] wd, input bit hold, output int lat, output int cs_n,
                          output logic we_f, output logic [3:0] be_f, output logic [31:0] rd,
                          output int at_cyc);
    req[k] = 1'b1; rnw[k] = rd_nwr; addr[k] = a; nbyte[k] = nb; wdata[k] = wd;
    lat = 0; cs_n = 0; we_f = 1'b0; be_f = 4'h0;
    while (lat < 40) begin
      cycle();
      lat++;
      if (cs[k]) begin
        cs_n++; we_f = we[k]; be_f = be[k];
      end
      if (ack[k]) break;
    end
    if (!ack[k]) chk("ack_timeout", 32'(ack[k]), 32'd1);
    rd = rdat[k];
    at_cyc = cyc;
    if (!hold) req[k] = 1'b0;
  endtask

  initial begin
    int lat, cs_n, at0, at1, at2, n, acks, cs_tot;
    logic we_f;
    logic [3:0] be_f;
    logic [31:0] rd;

    for (int k = 0; k < 2; k++) begin
      reset_model(k);
      for (int i = 0; i < 64; i++) mmem[k][i] = init_word(k, i);
      req[k] = 1'b0; addr[k] = '0; nbyte[k] = '0; rnw[k] = 1'b1; wdata[k] = '0;
    end
    rst = 1'b1;
    mem_init = 1'b1;
    req[0] = 1'b1; addr[0] = 18'h00010;

    // Reset held with a pending request: nothing happens
    for (int i = 0; i < 3; i++) begin
      cycle();
      mem_init = 1'b0;
      chk("rst_ack", 32'(ack[0]), 32'd0);
      chk("rst_cs", 32'(cs[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
    end
    rst = 1'b0;

    // Latency-1 read of DEADBEEF, accepted on the first edge after release
    run_xfer(0, 1'b1, 18'h00010, 4'h0, 32'h0, 1'b0, lat, cs_n, we_f, be_f, rd, at0);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_cs_n", 32'(cs_n), 32'd1);
    chk("rd_we", 32'(we_f), 32'd0);
    chk("rd_be", 32'(be_f), 32'hF);
    chk("rd_data", rd, 32'hDEADBEEF);
    cycle(); cycle();

    // Byte write to bytes 0 and 2
    run_xfer(0, 1'b0, 18'h00004, 4'b1010, 32'h11223344, 1'b0, lat, cs_n, we_f, be_f, rd, at0);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_be", 32'(be_f), 32'h5);
    chk("wr_we", 32'(we_f), 32'd1);
    chk("wr_keeps_rdata", rd, 32'hDEADBEEF);
    cycle(); cycle();
    chk("wr_sram_word", sram[0][4], 32'hC0220044);

    // Read back; byte enables ignored for reads
    run_xfer(0, 1'b1, 18'h00004, 4'b0110, 32'h0, 1'b0, lat, cs_n, we_f, be_f, rd, at0);
    chk("rdback_be", 32'(be_f), 32'hF);
    chk("rdback_data", rd, 32'hC0220044);
    cycle();

    // Write with every byte disabled still pulses the SRAM select and acks
    run_xfer(0, 1'b0, 18'h00005, 4'hF, 32'hFFFFFFFF, 1'b0, lat, cs_n, we_f, be_f, rd, at0);
    chk("nobyte_cs_n", 32'(cs_n), 32'd1);
    chk("nobyte_be", 32'(be_f), 32'h0);
    chk("nobyte_lat", 32'(lat), 32'd3);
    cycle(); cycle();
    chk("nobyte_sram", sram[0][5], 32'hC0DE0005);

    // Request dropped before ack: the transfer still completes
    req[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 18'h00010; nbyte[0] = 4'h0;
    cycle();
    req[0] = 1'b0;
    n = 1;
    while (!ack[0] && n < 20) begin
      cycle();
      n++;
    end
    chk("abort_lat", 32'(n), 32'd3);
    chk("abort_data", rdat[0], 32'hDEADBEEF);
    cycle(); cycle();

    // Back-to-back reads at latency 3 with the request held
    run_xfer(1, 1'b1, 18'h00001, 4'h0, 32'h0, 1'b1, lat, cs_n, we_f, be_f, rd, at0);
    chk("b2b_first_lat", 32'(lat), 32'd5);
    chk("b2b_rd0", rd, 32'hC0DE0101);
    cs_tot = cs_n;
    run_xfer(1, 1'b1, 18'h00002, 4'h0, 32'h0, 1'b1, lat, cs_n, we_f, be_f, rd, at1);
    chk("b2b_rd1", rd, 32'hC0DE0102);
    cs_tot += cs_n;
    run_xfer(1, 1'b1, 18'h00003, 4'h0, 32'h0, 1'b0, lat, cs_n, we_f, be_f, rd, at2);
    chk("b2b_rd2", rd, 32'hC0DE0103);
    cs_tot += cs_n;
    chk("b2b_gap1", 32'(at1 - at0), 32'd6);
    chk("b2b_gap2", 32'(at2 - at1), 32'd6);
    chk("b2b_cs_total", 32'(cs_tot), 32'd3);
    cycle(); cycle();

    // Reset during WAIT discards the transfer; a reissue completes
    req[1] = 1'b1; rnw[1] = 1'b1; addr[1] = 18'h00007;
    cycle(); cycle(); cycle();
    chk("midrst_busy_before", 32'(busy[1]), 32'd1);
    req[1] = 1'b0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      acks += int'(ack[1]);
    end
    chk("midrst_no_ack", 32'(acks), 32'd0);
    run_xfer(1, 1'b1, 18'h00007, 4'h0, 32'h0, 1'b0, lat, cs_n, we_f, be_f, rd, at0);
    chk("midrst_reissue_lat", 32'(lat), 32'd5);
    chk("midrst_reissue_data", rd, 32'hC0DE0107);
    cycle();

`ifdef DE_RESP_BOUNDS_EN
    // Out-of-range read: no SRAM select, zero data, sticky error
    run_xfer(0, 1'b1, 18'h00400, 4'h0, 32'h0, 1'b0, lat, cs_n, we_f, be_f, rd, at0);
    chk("oob_cs_n", 32'(cs_n), 32'd0);
    chk("oob_lat", 32'(lat), 32'd3);
    chk("oob_data", rd, 32'h0);
    chk("oob_err", 32'(err[0]), 32'd1);
    cycle();
    run_xfer(0, 1'b1, 18'h00010, 4'h0, 32'h0, 1'b0, lat, cs_n, we_f, be_f, rd, at0);
    chk("oob_after_legal_data", rd, 32'hDEADBEEF);
    chk("oob_err_sticky", 32'(err[0]), 32'd1);
    cycle();
`else
    chk("err_tied_low", 32'(err[0]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
